// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a 32-bit MIPS-subset datapath: sequences each instruction,
// drives datapath enables and extender mode, and handshakes with a shared memory port.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ext_sign,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             bus_err,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        RST, FETCH, DECODE,
        EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_R, WB_I, WB_MEM, BRANCH, JUMP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       timeout;
    logic       done;

    // funct is decoded by the ALU control when alu_op=111; the FSM itself never needs it.
    logic unused_funct;
    assign unused_funct = ^funct;

    // The cycle right after a timeout is a dead FETCH: the request is dropped for one cycle.
    assign mem_state = (state == FETCH && !bus_err) || state == MEM_RD || state == MEM_WR;
    assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    assign done      = (state inside {WB_R, WB_I, WB_MEM, BRANCH, JUMP})
                     || (state == MEM_WR && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST;
            wait_cnt    <= '0;
            ext_sign    <= 1'b0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
            retire      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            // NOTE: pulses default low every cycle; a later non-blocking write in this block wins.
            illegal <= 1'b0;
            bus_err <= 1'b0;
            retire  <= done;
            if (done)
                retired_cnt <= retired_cnt + CNT_W'(1);

            if (!mem_state || mem_ready || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 8'd1;

            if (timeout) begin
                bus_err <= 1'b1;
                state   <= FETCH;
            end else begin
                case (state)
                    RST:      state <= FETCH;
                    FETCH:    if (!bus_err && mem_ready) state <= DECODE;
                    DECODE: begin
                        case (opcode)
                            OP_RTYPE: state <= EXEC_R;
                            OP_ADDI, OP_SLTI: begin
                                ext_sign <= 1'b1;
                                state    <= EXEC_I;
                            end
                            OP_ANDI, OP_ORI: begin
                                ext_sign <= 1'b0;
                                state    <= EXEC_I;
                            end
                            OP_LW, OP_SW: begin
                                ext_sign <= 1'b1;
                                state    <= MEM_ADDR;
                            end
                            OP_BEQ: begin
                                ext_sign <= 1'b1;
                                state    <= BRANCH;
                            end
                            OP_J:     state <= JUMP;
                            default: begin
                                illegal <= 1'b1;
                                state   <= FETCH;
                            end
                        endcase
                    end
                    EXEC_R:   state <= WB_R;
                    EXEC_I:   state <= WB_I;
                    MEM_ADDR: state <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
                    MEM_RD:   if (mem_ready) state <= WB_MEM;
                    MEM_WR:   if (mem_ready) state <= FETCH;
                    WB_R, WB_I, WB_MEM, BRANCH, JUMP: state <= FETCH;
                    default:  state <= RST;
                endcase
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = !bus_err;
                alu_src_b = 2'b01;
                if (!bus_err && mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            DECODE:   alu_src_b = 2'b11;
            EXEC_R: begin
                alu_src_b = 2'b00;
                alu_op    = 3'b111;
            end
            EXEC_I: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_SLTI: alu_op = 3'b100;
                    OP_ANDI: alu_op = 3'b010;
                    OP_ORI:  alu_op = 3'b011;
                    default: alu_op = 3'b000;
                endcase
            end
            MEM_ADDR: alu_src_b = 2'b10;
            MEM_RD:   mem_req = 1'b1;
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            WB_I:     reg_write = 1'b1;
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            BRANCH: begin
                alu_op = 3'b001;
                if (zero) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b01;
                end
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// against hand-computed control words and flag pulses.
module tb_multicycle_ctrl;
    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, ir_write, pc_write, ext_sign;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_write, reg_dst, mem_to_reg, illegal, bus_err, retire;
    logic [31:0] retired_cnt;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .ext_sign(ext_sign), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .bus_err(bus_err), .retire(retire), .retired_cnt(retired_cnt)
    );

    // Control word: {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg}
    logic [13:0] ctl;
    logic [3:0]  flg;
    assign ctl = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b, alu_op,
                  reg_write, reg_dst, mem_to_reg};
    assign flg = {ext_sign, illegal, bus_err, retire};

    localparam logic [13:0] C_RST   = 14'b0000_00_00_000_000;
    localparam logic [13:0] C_FWAIT = 14'b1000_00_01_000_000;
    localparam logic [13:0] C_FRDY  = 14'b1011_00_01_000_000;
    localparam logic [13:0] C_FHOLD = 14'b0000_00_01_000_000;
    localparam logic [13:0] C_DEC   = 14'b0000_00_11_000_000;
    localparam logic [13:0] C_EXR   = 14'b0000_00_00_111_000;
    localparam logic [13:0] C_WBR   = 14'b0000_00_00_000_110;
    localparam logic [13:0] C_EXADD = 14'b0000_00_10_000_000;
    localparam logic [13:0] C_EXAND = 14'b0000_00_10_010_000;
    localparam logic [13:0] C_WBI   = 14'b0000_00_00_000_100;
    localparam logic [13:0] C_MADR  = 14'b0000_00_10_000_000;
    localparam logic [13:0] C_MRD   = 14'b1000_00_00_000_000;
    localparam logic [13:0] C_WBM   = 14'b0000_00_00_000_101;
    localparam logic [13:0] C_MWR   = 14'b1100_00_00_000_000;
    localparam logic [13:0] C_BRT   = 14'b0001_01_00_001_000;
    localparam logic [13:0] C_BRN   = 14'b0000_00_00_001_000;
    localparam logic [13:0] C_JMP   = 14'b0001_10_00_000_000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive mem_ready, check the current state's outputs, advance one clock.
    task automatic step(input string tag, input logic rdy, input logic [13:0] exp_ctl,
                        input logic [3:0] exp_flg);
        mem_ready = rdy;
        #1;
        check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        check({tag, "_flg"}, 32'(flg), 32'(exp_flg));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por_ctl", 32'(ctl), 32'(C_RST));
        check("por_flg", 32'(flg), 32'h0);
        check("por_cnt", retired_cnt, 32'd0);
        rst_n = 1'b1;
        step("rst_idle", 1'b0, C_RST, 4'b0000);

        // addi then andi: extender mode follows the opcode, 4 cycles each
        opcode = 6'b001000;
        step("addi_f", 1'b1, C_FRDY,  4'b0000);
        step("addi_d", 1'b1, C_DEC,   4'b0000);
        step("addi_x", 1'b1, C_EXADD, 4'b1000);
        step("addi_w", 1'b1, C_WBI,   4'b1000);
        check("cnt_addi", retired_cnt, 32'd1);
        opcode = 6'b001100;
        step("andi_f", 1'b1, C_FRDY,  4'b1001);
        step("andi_d", 1'b1, C_DEC,   4'b1000);
        step("andi_x", 1'b1, C_EXAND, 4'b0000);
        step("andi_w", 1'b1, C_WBI,   4'b0000);
        check("cnt_andi", retired_cnt, 32'd2);

        // j leaves ext_sign alone; then an R-type
        opcode = 6'b000010;
        step("j_f", 1'b1, C_FRDY, 4'b0001);
        step("j_d", 1'b1, C_DEC,  4'b0000);
        step("j_x", 1'b1, C_JMP,  4'b0000);
        check("cnt_j", retired_cnt, 32'd3);
        opcode = 6'b000000;
        step("r_f", 1'b1, C_FRDY, 4'b0001);
        step("r_d", 1'b1, C_DEC,  4'b0000);
        step("r_x", 1'b1, C_EXR,  4'b0000);
        step("r_w", 1'b1, C_WBR,  4'b0000);
        check("cnt_r", retired_cnt, 32'd4);

        // lw with three stall cycles in MEM_RD: 8 cycles total
        opcode = 6'b100011;
        step("lw_f", 1'b1, C_FRDY, 4'b0001);
        step("lw_d", 1'b1, C_DEC,  4'b0000);
        step("lw_a", 1'b1, C_MADR, 4'b1000);
        for (int i = 0; i < 3; i++) step("lw_stall", 1'b0, C_MRD, 4'b1000);
        step("lw_rd", 1'b1, C_MRD, 4'b1000);
        step("lw_wb", 1'b1, C_WBM, 4'b1000);
        check("cnt_lw", retired_cnt, 32'd5);

        // beq taken then not taken
        opcode = 6'b000100;
        zero = 1'b1;
        step("beqt_f", 1'b1, C_FRDY, 4'b1001);
        step("beqt_d", 1'b1, C_DEC,  4'b1000);
        step("beqt_b", 1'b1, C_BRT,  4'b1000);
        check("cnt_beqt", retired_cnt, 32'd6);
        zero = 1'b0;
        step("beqn_f", 1'b1, C_FRDY, 4'b1001);
        step("beqn_d", 1'b1, C_DEC,  4'b1000);
        step("beqn_b", 1'b1, C_BRN,  4'b1000);
        check("cnt_beqn", retired_cnt, 32'd7);

        // sw with mem_ready stuck low: 8 wait cycles, then bus_err and a dropped request
        opcode = 6'b101011;
        step("sw_f", 1'b1, C_FRDY, 4'b1001);
        step("sw_d", 1'b1, C_DEC,  4'b1000);
        step("sw_a", 1'b1, C_MADR, 4'b1000);
        for (int i = 0; i < 8; i++) step("sw_wait", 1'b0, C_MWR, 4'b1000);
        step("sw_berr", 1'b0, C_FHOLD, 4'b1010);
        check("cnt_sw", retired_cnt, 32'd7);

        // fetch stalls 7 cycles, then mem_ready on the timeout cycle wins
        opcode = 6'b111111;
        for (int i = 0; i < 7; i++) step("fw_wait", 1'b0, C_FWAIT, 4'b1000);
        step("fw_edge", 1'b1, C_FRDY, 4'b1000);
        step("ill_d",   1'b1, C_DEC,  4'b1000);
        opcode = 6'b100011;
        step("ill_f",   1'b1, C_FRDY, 4'b1100);
        check("cnt_ill", retired_cnt, 32'd7);

        // reset asserted in the middle of a stalled lw
        step("lw2_d", 1'b1, C_DEC,  4'b1000);
        step("lw2_a", 1'b1, C_MADR, 4'b1000);
        step("lw2_s", 1'b0, C_MRD,  4'b1000);
        step("lw2_s", 1'b0, C_MRD,  4'b1000);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("mid_ctl", 32'(ctl), 32'(C_RST));
        check("mid_flg", 32'(flg), 32'h0);
        check("mid_cnt", retired_cnt, 32'd0);
        @(posedge clk);
        #1;
        check("mid_hold_ctl", 32'(ctl), 32'(C_RST));
        rst_n = 1'b1;
        step("rel_rst", 1'b1, C_RST,  4'b0000);
        step("rel_f",   1'b1, C_FRDY, 4'b0000);
        check("rel_cnt", retired_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
